hub75_fb_page_ctrl: RTL and testbench
=====================================

# hub75_fb_page_ctrl

Double-buffer page controller and write arbiter for the HUB75 frame buffer. Sits between the host pixel-write port and a two-page frame buffer RAM. Host writes and an internal clear engine share the back page. Page swaps happen only at a scanner frame boundary, so a frame never tears. The scanner reads the page given by `o_rd_page`; the HUB75 control/timer path is unchanged.

## Interface
- `hpixel_p`, 64, display width in pixels
- `vpixel_p`, 64, display height in pixels
- `bpp_p`, 8, bits per colour channel
- `frame_size_p`, localparam `hpixel_p*vpixel_p`, pixels per page
- `addr_width_p`, localparam `$clog2(frame_size_p)`, pixel address width
- One clock; reset is asynchronous and active-low.
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `i_enable` in 1: display scanning active.
- `i_wr_addr` in `addr_width_p`: host pixel address.
- `i_wr_data` in `3*bpp_p`: host pixel, packed `{R,G,B}`.
- `i_wr_en` in 1: host write valid.
- `o_wr_ready` out 1: host write accepted when `i_wr_en && o_wr_ready`.
- `i_clear_req` in 1: single-cycle pulse; fill the back page with `i_clear_color`.
- `i_clear_color` in `3*bpp_p`: fill value, sampled with `i_clear_req`.
- `o_clear_busy` out 1: clear in progress.
- `i_swap_req` in 1: single-cycle pulse; present the back page at the next frame boundary.
- `o_swap_pending` out 1: swap requested, not yet done.
- `o_swap_done` out 1: single-cycle pulse in the cycle `o_rd_page` toggles.
- `i_frame_end` in 1: pulse from the scanner after the last bit-plane of the last row.
- `o_rd_page` out 1: page the scanner reads (front page).
- `o_mem_wr_addr` out `addr_width_p+1`: RAM write address; MSB is the page (`~o_rd_page`).
- `o_mem_wr_data` out `3*bpp_p`: RAM write data.
- `o_mem_wr_en` out 1: RAM write strobe.

## Operation
- The write page is always `~o_rd_page`. The front page is never written.
- FSM states: IDLE, CLEAR, SWAP_WAIT.
- **IDLE:** `o_wr_ready`=1, and host writes pass through.
  - `i_clear_req` moves the FSM to CLEAR.
  - Otherwise `i_swap_req` moves it to SWAP_WAIT.
- **CLEAR:** `o_wr_ready`=0.
  - Counter k runs 0..`frame_size_p`-1 and issues one write per cycle with data = latched colour.
  - After the last write: go to SWAP_WAIT if a swap is latched, else IDLE.
- **SWAP_WAIT:** `o_wr_ready`=0.
  - On `i_frame_end`, or any cycle with `i_enable`=0: toggle `o_rd_page`, pulse `o_swap_done`, clear `o_swap_pending`, go to IDLE.
- Simultaneous events and ignored requests:
  - `i_clear_req` and `i_swap_req` together in IDLE: clear runs first and the swap is latched.
  - `i_swap_req` during CLEAR: latched.
  - `i_clear_req` during CLEAR or SWAP_WAIT: ignored.
  - `i_swap_req` during SWAP_WAIT: ignored (no double toggle).
  - `i_frame_end` in IDLE or CLEAR: ignored.
  - `i_frame_end` in the same cycle as an `i_swap_req` in IDLE: does not complete that swap; the swap waits for the next `i_frame_end`.
- Host writes while `o_wr_ready`=0 are not stored. The host holds `i_wr_en` until accepted.
- `o_swap_pending` = 1 from the cycle after `i_swap_req` is taken until `o_swap_done`.
- Reset mid-operation: the clear aborts, the latched swap is discarded and `o_rd_page` returns to 0. Page contents are undefined.

## Timing
- Reset values:
  - `o_rd_page`=0, `o_mem_wr_en`=0, `o_mem_wr_addr`=0, `o_mem_wr_data`=0.
  - `o_swap_pending`=0, `o_swap_done`=0, `o_clear_busy`=0.
  - `o_wr_ready`=1; FSM in IDLE.
- `o_mem_wr_*` are registered. An accepted host write at edge N appears on the RAM port in cycle N+1.
- Clear request sampled at edge N:
  - `o_clear_busy`=1 from N+1.
  - Address k appears in cycle N+1+k.
  - `o_clear_busy` falls the cycle after the last write.
  - Total `frame_size_p` writes.
- `o_wr_ready` is a combinational decode of the FSM state.
- `i_frame_end` sampled at edge M in SWAP_WAIT: `o_rd_page` toggles and `o_swap_done`=1 in cycle M+1.

## Configuration
- `HUB75_FB_CLEAR_EN` defined: clear engine compiled in as described.
- Not defined:
  - No CLEAR state or counter; `i_clear_req` and `i_clear_color` are ignored; `o_clear_busy` is tied 0.
  - Swap and host-write behaviour is unchanged.

## Structure
- `hub75_pkg` holds the FSM enum `fb_state_e` and a `pixel_t` typedef (`3*bpp_p` packed RGB).
- Sub-module `hub75_fb_clear_gen`, instantiated only under `HUB75_FB_CLEAR_EN`:
  - Inputs: start and colour.
  - Outputs: address, data, valid, done.

## Test plan
- Reset, then host writes addr 5 = 0xFF0000: `o_mem_wr_addr`=0x1005 (page bit 1, 64x64), data 0xFF0000 one cycle later; `o_rd_page`=0.
- `i_swap_req`, then `i_frame_end` 100 cycles later: `o_swap_pending`=1 throughout; `o_rd_page`=1 and `o_swap_done` pulse one cycle after frame end; next host write uses page bit 0.
- `i_clear_req` with colour 0x00FF00:
  - exactly 4096 consecutive writes, addresses 0..4095, all 0x00FF00;
  - `o_wr_ready`=0 throughout; a host write held pending is accepted afterward.
- Clear and swap requested in the same cycle: the swap completes only at the first `i_frame_end` after the clear finishes; `i_frame_end` pulses during the clear are ignored.
- `i_swap_req` with `i_enable`=0: page toggles two cycles after the request with no `i_frame_end`.
- `rst_n` asserted mid-clear (k=1000): all outputs return to reset values immediately, and no further writes occur.

Source files
------------

// File: rtl/hub75_pkg.sv
// Shared types for the HUB75 frame-buffer page controller.
package hub75_pkg;

    localparam int bpp_c = 8;

    typedef logic [3*bpp_c-1:0] pixel_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } fb_state_e;

endpackage

// File: rtl/hub75_fb_clear_gen.sv
// Back-page fill sequencer: one write per cycle, address 0 on the start cycle itself.
module hub75_fb_clear_gen #(
    parameter int frame_size_p = 4096,
    parameter int addr_width_p = 12,
    parameter int data_width_p = 24
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [data_width_p-1:0] color,
    output logic [addr_width_p-1:0] addr,
    output logic [data_width_p-1:0] data,
    output logic                    valid,
    output logic                    done
);

    localparam logic [addr_width_p-1:0] last_c = addr_width_p'(frame_size_p - 1);

    logic                    active;
    logic                    done_r;
    logic [addr_width_p-1:0] cnt;
    logic [data_width_p-1:0] col;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active <= 1'b0;
            done_r <= 1'b0;
            cnt    <= '0;
            col    <= '0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                active <= 1'b1;
                cnt    <= addr_width_p'(1);
                col    <= color;
            end else if (active) begin
                cnt <= cnt + addr_width_p'(1);
                if (cnt == last_c) begin
                    active <= 1'b0;
                    done_r <= 1'b1;
                end
            end
        end
    end

    // Start cycle bypasses the registers so address 0 is issued with the request.
    assign valid = start | active;
    assign addr  = active ? cnt : '0;
    assign data  = active ? col : color;
    assign done  = done_r;

endmodule

// File: rtl/hub75_fb_page_ctrl.sv
// Double-buffer page controller / back-page write arbiter for the HUB75 frame buffer.
// Define HUB75_FB_CLEAR_EN to build in the back-page clear engine.
module hub75_fb_page_ctrl
    import hub75_pkg::*;
#(
    parameter int hpixel_p = 64,
    parameter int vpixel_p = 64,
    parameter int bpp_p    = 8,
    localparam int frame_size_p = hpixel_p * vpixel_p,
    localparam int addr_width_p = $clog2(frame_size_p)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_enable,
    input  logic [addr_width_p-1:0] i_wr_addr,
    input  logic [3*bpp_p-1:0]      i_wr_data,
    input  logic                    i_wr_en,
    output logic                    o_wr_ready,
    input  logic                    i_clear_req,
    input  logic [3*bpp_p-1:0]      i_clear_color,
    output logic                    o_clear_busy,
    input  logic                    i_swap_req,
    output logic                    o_swap_pending,
    output logic                    o_swap_done,
    input  logic                    i_frame_end,
    output logic                    o_rd_page,
    output logic [addr_width_p:0]   o_mem_wr_addr,
    output logic [3*bpp_p-1:0]      o_mem_wr_data,
    output logic                    o_mem_wr_en
);

    fb_state_e state, state_nxt;

    logic                    wr_fire, swap_take, swap_fire;
    logic                    clr_start, clr_valid, clr_done;
    logic [addr_width_p-1:0] clr_addr;
    logic [3*bpp_p-1:0]      clr_data;

    assign o_wr_ready = (state == ST_IDLE);
    assign wr_fire    = i_wr_en && o_wr_ready;

`ifdef HUB75_FB_CLEAR_EN
    assign clr_start    = (state == ST_IDLE) && i_clear_req;
    assign o_clear_busy = (state == ST_CLEAR);

    hub75_fb_clear_gen #(
        .frame_size_p (frame_size_p),
        .addr_width_p (addr_width_p),
        .data_width_p (3*bpp_p)
    ) u_clear_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .start (clr_start),
        .color (i_clear_color),
        .addr  (clr_addr),
        .data  (clr_data),
        .valid (clr_valid),
        .done  (clr_done)
    );
`else
    logic unused_clear;
    assign unused_clear = ^{i_clear_req, i_clear_color};
    assign clr_start    = 1'b0;
    assign clr_valid    = 1'b0;
    assign clr_done     = 1'b0;
    assign clr_addr     = '0;
    assign clr_data     = '0;
    assign o_clear_busy = 1'b0;
`endif

    assign swap_take = i_swap_req && ((state == ST_IDLE) || (state == ST_CLEAR));
    assign swap_fire = (state == ST_SWAP_WAIT) && (i_frame_end || !i_enable);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_start)       state_nxt = ST_CLEAR;
                else if (i_swap_req) state_nxt = ST_SWAP_WAIT;
            end
            ST_CLEAR: begin
                if (clr_done)
                    state_nxt = (o_swap_pending || i_swap_req) ? ST_SWAP_WAIT : ST_IDLE;
            end
            ST_SWAP_WAIT: begin
                if (swap_fire) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_page      <= 1'b0;
            o_swap_pending <= 1'b0;
            o_swap_done    <= 1'b0;
            o_mem_wr_en    <= 1'b0;
            o_mem_wr_addr  <= '0;
            o_mem_wr_data  <= '0;
        end else begin
            o_swap_done <= swap_fire;
            if (swap_fire) begin
                o_rd_page      <= ~o_rd_page;
                o_swap_pending <= 1'b0;
            end else if (swap_take) begin
                o_swap_pending <= 1'b1;
            end
            // A host write landing with the clear start is dropped: the fill overwrites it anyway.
            o_mem_wr_en <= clr_valid || wr_fire;
            if (clr_valid) begin
                o_mem_wr_addr <= {~o_rd_page, clr_addr};
                o_mem_wr_data <= clr_data;
            end else if (wr_fire) begin
                o_mem_wr_addr <= {~o_rd_page, i_wr_addr};
                o_mem_wr_data <= i_wr_data;
            end
        end
    end

endmodule

// File: tb/tb_hub75_fb_page_ctrl.sv
// Directed bench for hub75_fb_page_ctrl (64x64, 8 bpp); clear tests follow HUB75_FB_CLEAR_EN.
module tb_hub75_fb_page_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [11:0] wr_addr;
    logic [23:0] wr_data;
    logic        wr_en;
    logic        wr_ready;
    logic        clear_req;
    logic [23:0] clear_color;
    logic        clear_busy;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        frame_end;
    logic        rd_page;
    logic [12:0] mem_wr_addr;
    logic [23:0] mem_wr_data;
    logic        mem_wr_en;

    int n_checks = 0;
    int n_fail   = 0;
    logic exp_page = 1'b0;

    always #5 clk = ~clk;

    hub75_fb_page_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_enable       (enable),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_wr_en        (wr_en),
        .o_wr_ready     (wr_ready),
        .i_clear_req    (clear_req),
        .i_clear_color  (clear_color),
        .o_clear_busy   (clear_busy),
        .i_swap_req     (swap_req),
        .o_swap_pending (swap_pending),
        .o_swap_done    (swap_done),
        .i_frame_end    (frame_end),
        .o_rd_page      (rd_page),
        .o_mem_wr_addr  (mem_wr_addr),
        .o_mem_wr_data  (mem_wr_data),
        .o_mem_wr_en    (mem_wr_en)
    );

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; enable = 1'b1; wr_addr = '0; wr_data = '0; wr_en = 1'b0;
        clear_req = 1'b0; clear_color = '0; swap_req = 1'b0; frame_end = 1'b0;
        #3;
        n_checks++;
        if ({rd_page, mem_wr_en, swap_pending, swap_done, clear_busy, wr_ready} !== 6'b000001) begin
            n_fail++; $display("FAIL reset_flags: got %b exp 000001",
                {rd_page, mem_wr_en, swap_pending, swap_done, clear_busy, wr_ready});
        end
        n_checks++;
        if ({mem_wr_addr, mem_wr_data} !== 37'd0) begin
            n_fail++; $display("FAIL reset_mem: got addr %h data %h exp 0", mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step;
    endtask

    task automatic test_host_write;
        wr_en = 1'b1; wr_addr = 12'd5; wr_data = 24'hFF0000;
        step;
        wr_en = 1'b0;
        n_checks++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, 13'h1005, 24'hFF0000}) begin
            n_fail++; $display("FAIL host_write: got en %b addr %h data %h exp 1 1005 ff0000",
                mem_wr_en, mem_wr_addr, mem_wr_data);
        end
        n_checks++;
        if (rd_page !== 1'b0) begin
            n_fail++; $display("FAIL host_rd_page: got %b exp 0", rd_page);
        end
        step;
        n_checks++;
        if (mem_wr_en !== 1'b0) begin
            n_fail++; $display("FAIL host_write_drop: got en %b exp 0", mem_wr_en);
        end
    endtask

    task automatic test_swap;
        int bad = 0;
        // Frame end coincident with the request must not complete it.
        swap_req = 1'b1; frame_end = 1'b1;
        step;
        swap_req = 1'b0; frame_end = 1'b0;
        n_checks++;
        if ({swap_pending, wr_ready, rd_page} !== {2'b10, exp_page}) begin
            n_fail++; $display("FAIL swap_start: got pend/rdy/page %b exp %b",
                {swap_pending, wr_ready, rd_page}, {2'b10, exp_page});
        end
        for (int i = 0; i < 99; i++) begin
            if (i == 50) swap_req = 1'b1;
            step;
            swap_req = 1'b0;
            if (swap_pending !== 1'b1 || rd_page !== exp_page || swap_done !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL swap_wait_hold: got %0d bad cycles exp 0", bad);
        end
        frame_end = 1'b1;
        step;
        frame_end = 1'b0;
        exp_page = ~exp_page;
        n_checks++;
        if ({rd_page, swap_done, swap_pending, wr_ready} !== {exp_page, 3'b101}) begin
            n_fail++; $display("FAIL swap_done: got page/done/pend/rdy %b exp %b",
                {rd_page, swap_done, swap_pending, wr_ready}, {exp_page, 3'b101});
        end
        step;
        n_checks++;
        if ({rd_page, swap_done} !== {exp_page, 1'b0}) begin
            n_fail++; $display("FAIL swap_single: got page/done %b exp %b",
                {rd_page, swap_done}, {exp_page, 1'b0});
        end
        wr_en = 1'b1; wr_addr = 12'd7; wr_data = 24'h0000FF;
        step;
        wr_en = 1'b0;
        n_checks++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, ~exp_page, 12'd7, 24'h0000FF}) begin
            n_fail++; $display("FAIL swap_wr_page: got en %b addr %h exp addr %h",
                mem_wr_en, mem_wr_addr, {~exp_page, 12'd7});
        end
    endtask

    task automatic test_swap_disabled;
        enable = 1'b0; swap_req = 1'b1;
        step;
        swap_req = 1'b0;
        n_checks++;
        if ({rd_page, swap_pending, swap_done} !== {exp_page, 2'b10}) begin
            n_fail++; $display("FAIL noen_first: got page/pend/done %b exp %b",
                {rd_page, swap_pending, swap_done}, {exp_page, 2'b10});
        end
        step;
        exp_page = ~exp_page;
        n_checks++;
        if ({rd_page, swap_pending, swap_done} !== {exp_page, 2'b01}) begin
            n_fail++; $display("FAIL noen_toggle: got page/pend/done %b exp %b",
                {rd_page, swap_pending, swap_done}, {exp_page, 2'b01});
        end
        enable = 1'b1;
        step;
    endtask

`ifdef HUB75_FB_CLEAR_EN
    task automatic test_clear;
        int bad = 0;
        clear_req = 1'b1; clear_color = 24'h00FF00;
        step;
        clear_req = 1'b0; clear_color = 24'h0;
        wr_en = 1'b1; wr_addr = 12'd9; wr_data = 24'h123456;
        for (int k = 0; k < 4096; k++) begin
            if (mem_wr_en !== 1'b1 || mem_wr_addr !== {~exp_page, 12'(k)} ||
                mem_wr_data !== 24'h00FF00 || wr_ready !== 1'b0 || clear_busy !== 1'b1) begin
                if (bad == 0) $display("FAIL clear_write_k%0d: got en %b addr %h data %h rdy %b exp 1 %h 00ff00 0",
                    k, mem_wr_en, mem_wr_addr, mem_wr_data, wr_ready, {~exp_page, 12'(k)});
                bad++;
            end
            step;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL clear_sequence: got %0d bad cycles exp 0", bad);
        end
        n_checks++;
        if ({clear_busy, wr_ready, mem_wr_en} !== 3'b010) begin
            n_fail++; $display("FAIL clear_end: got busy/rdy/en %b exp 010",
                {clear_busy, wr_ready, mem_wr_en});
        end
        step;
        wr_en = 1'b0;
        n_checks++;
        if ({mem_wr_en, mem_wr_addr, mem_wr_data} !== {1'b1, ~exp_page, 12'd9, 24'h123456}) begin
            n_fail++; $display("FAIL clear_held_write: got en %b addr %h data %h exp 1 %h 123456",
                mem_wr_en, mem_wr_addr, mem_wr_data, {~exp_page, 12'd9});
        end
        step;
    endtask

    task automatic test_clear_swap;
        int bad = 0;
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 24'h000000;
        step;
        clear_req = 1'b0; swap_req = 1'b0;
        for (int k = 0; k < 4096; k++) begin
            frame_end = (k == 10 || k == 4095);
            if (rd_page !== exp_page || swap_pending !== 1'b1 || swap_done !== 1'b0 ||
                clear_busy !== 1'b1) bad++;
            step;
            frame_end = 1'b0;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL clrswap_during: got %0d bad cycles exp 0", bad);
        end
        repeat (5) step;
        n_checks++;
        if ({clear_busy, wr_ready, swap_pending, rd_page} !== {3'b001, exp_page}) begin
            n_fail++; $display("FAIL clrswap_wait: got busy/rdy/pend/page %b exp %b",
                {clear_busy, wr_ready, swap_pending, rd_page}, {3'b001, exp_page});
        end
        frame_end = 1'b1;
        step;
        frame_end = 1'b0;
        exp_page = ~exp_page;
        n_checks++;
        if ({rd_page, swap_done, swap_pending} !== {exp_page, 2'b10}) begin
            n_fail++; $display("FAIL clrswap_done: got page/done/pend %b exp %b",
                {rd_page, swap_done, swap_pending}, {exp_page, 2'b10});
        end
        step;
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        clear_req = 1'b1; swap_req = 1'b1; clear_color = 24'hABCDEF;
        step;
        clear_req = 1'b0; swap_req = 1'b0;
        repeat (1000) step;
        n_checks++;
        if ({mem_wr_en, mem_wr_addr[11:0]} !== {1'b1, 12'd1000}) begin
            n_fail++; $display("FAIL rst_mid_pos: got en %b k %0d exp 1 1000", mem_wr_en, mem_wr_addr[11:0]);
        end
        #2 rst_n = 1'b0;
        #1;
        exp_page = 1'b0;
        n_checks++;
        if ({rd_page, mem_wr_en, swap_pending, swap_done, clear_busy, wr_ready, mem_wr_addr, mem_wr_data}
            !== {6'b000001, 37'd0}) begin
            n_fail++; $display("FAIL rst_mid_values: got page %b en %b pend %b busy %b rdy %b addr %h data %h",
                rd_page, mem_wr_en, swap_pending, clear_busy, wr_ready, mem_wr_addr, mem_wr_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            frame_end = (i == 5);
            step;
            frame_end = 1'b0;
            if (mem_wr_en !== 1'b0 || clear_busy !== 1'b0 || rd_page !== 1'b0 || swap_pending !== 1'b0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got %0d bad cycles exp 0", bad);
        end
    endtask
`else
    task automatic test_clear_ignored;
        int bad = 0;
        clear_req = 1'b1; clear_color = 24'h00FF00;
        step;
        clear_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (clear_busy !== 1'b0 || wr_ready !== 1'b1 || mem_wr_en !== 1'b0) bad++;
            step;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL clear_ignored: got %0d bad cycles exp 0", bad);
        end
    endtask

    task automatic test_reset_mid;
        swap_req = 1'b1;
        step;
        swap_req = 1'b0;
        step;
        #2 rst_n = 1'b0;
        #1;
        exp_page = 1'b0;
        n_checks++;
        if ({rd_page, swap_pending, wr_ready, mem_wr_en} !== 4'b0010) begin
            n_fail++; $display("FAIL rst_mid_values: got page/pend/rdy/en %b exp 0010",
                {rd_page, swap_pending, wr_ready, mem_wr_en});
        end
        @(negedge clk);
        rst_n = 1'b1;
        frame_end = 1'b1;
        step;
        frame_end = 1'b0;
        n_checks++;
        if ({rd_page, swap_done} !== 2'b00) begin
            n_fail++; $display("FAIL rst_mid_discard: got page/done %b exp 00", {rd_page, swap_done});
        end
    endtask
`endif

    initial begin
        test_reset;
        test_host_write;
        test_swap;
`ifdef HUB75_FB_CLEAR_EN
        test_clear;
        test_clear_swap;
`else
        test_clear_ignored;
`endif
        test_swap_disabled;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
